// File: rtl/pipe_buffer_ifid.sv
// IF/ID pipeline buffer: registered main stage plus one skid entry, valid/ready on both sides, flush-to-NOP.
// Optional stall/flush perf counters are built only when IFID_PERF_CNT_EN is defined.
module pipe_buffer_ifid #(
  parameter int                 INSTR_W   = 16,
  parameter int                 CTRL_W    = 1,
  parameter int                 PC_W      = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INSTR_W-1:0] in_instr_i,
  input  logic [CTRL_W-1:0]  in_ctrl_i,
  input  logic [PC_W-1:0]    in_pc_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               flush_i,
  output logic [INSTR_W-1:0] out_instr_o,
  output logic [CTRL_W-1:0]  out_ctrl_o,
  output logic [PC_W-1:0]    out_pc_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [CNT_W-1:0]   stall_count_o,
  output logic [CNT_W-1:0]   flush_count_o
);

  localparam int E_W = INSTR_W + CTRL_W + PC_W;
  localparam logic [E_W-1:0] NOP_ENTRY = {NOP_INSTR, {CTRL_W{1'b0}}, {PC_W{1'b0}}};

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t         state_q, state_d;
  logic [E_W-1:0] main_q, main_d;
  logic [E_W-1:0] skid_q, skid_d;
  logic [E_W-1:0] in_entry;
  logic           push, pop;

  assign in_entry    = {in_instr_i, in_ctrl_i, in_pc_i};
  assign out_valid_o = (state_q != EMPTY);
  assign in_ready_o  = (state_q != FULL);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  assign {out_instr_o, out_ctrl_o, out_pc_o} = main_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // Flush wins over everything: held and incoming entries are dropped.
      state_d = EMPTY;
      main_d  = NOP_ENTRY;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            main_d  = in_entry;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = in_entry;
          end else if (push) begin
            state_d = FULL;
            skid_d  = in_entry;
          end else if (pop) begin
            state_d = EMPTY;
            main_d  = NOP_ENTRY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_ENTRY;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= NOP_ENTRY;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef IFID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters; only reset clears them.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid_o && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_i && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count_o = stall_cnt_q;
  assign flush_count_o = flush_cnt_q;
`else
  assign stall_count_o = '0;
  assign flush_count_o = '0;
`endif

endmodule

// File: tb/tb_pipe_buffer_ifid.sv
// Directed bench for pipe_buffer_ifid: vector table plus async-reset and perf-counter sequences.
module tb_pipe_buffer_ifid;

  localparam logic [15:0] NOP = 16'hC000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_instr = '0;
  logic [0:0]  in_ctrl = '0;
  logic [15:0] in_pc = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [15:0] out_instr;
  logic [0:0]  out_ctrl;
  logic [15:0] out_pc;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] stall_count, flush_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_buffer_ifid #(
    .INSTR_W(16), .CTRL_W(1), .PC_W(16), .NOP_INSTR(NOP), .CNT_W(16)
  ) u_dut (
    .clk_i(clk), .rst_i(rst),
    .in_instr_i(in_instr), .in_ctrl_i(in_ctrl), .in_pc_i(in_pc),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .flush_i(flush),
    .out_instr_o(out_instr), .out_ctrl_o(out_ctrl), .out_pc_o(out_pc),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .stall_count_o(stall_count), .flush_count_o(flush_count)
  );

`ifdef IFID_PERF_CNT_EN
  logic        s_in_ready, s_out_valid;
  logic [15:0] s_out_instr, s_out_pc;
  logic [0:0]  s_out_ctrl;
  logic [2:0]  s_stall_count, s_flush_count;

  pipe_buffer_ifid #(
    .INSTR_W(16), .CTRL_W(1), .PC_W(16), .NOP_INSTR(NOP), .CNT_W(3)
  ) u_dut_sat (
    .clk_i(clk), .rst_i(rst),
    .in_instr_i(in_instr), .in_ctrl_i(in_ctrl), .in_pc_i(in_pc),
    .in_valid_i(in_valid), .in_ready_o(s_in_ready), .flush_i(flush),
    .out_instr_o(s_out_instr), .out_ctrl_o(s_out_ctrl), .out_pc_o(s_out_pc),
    .out_valid_o(s_out_valid), .out_ready_i(out_ready),
    .stall_count_o(s_stall_count), .flush_count_o(s_flush_count)
  );
`endif

  typedef struct {
    logic        vld;
    logic [15:0] instr;
    logic        ctrl;
    logic [15:0] pc;
    logic        rdy;
    logic        fl;
    logic        e_vld;
    logic [15:0] e_instr;
    logic        e_ctrl;
    logic [15:0] e_pc;
    logic        e_ir;
  } vec_t;

  vec_t vt [19];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(input int idx, input logic e_vld, input logic [15:0] e_instr,
                            input logic e_ctrl, input logic [15:0] e_pc, input logic e_ir);
    check("out_valid", idx, 32'(out_valid), 32'(e_vld));
    check("out_instr", idx, 32'(out_instr), 32'(e_instr));
    check("out_ctrl",  idx, 32'(out_ctrl),  32'(e_ctrl));
    check("out_pc",    idx, 32'(out_pc),    32'(e_pc));
    check("in_ready",  idx, 32'(in_ready),  32'(e_ir));
  endtask

  task automatic drive(input logic vld, input logic [15:0] instr, input logic ctrl,
                       input logic [15:0] pc, input logic rdy, input logic fl);
    in_valid  = vld;
    in_instr  = instr;
    in_ctrl   = ctrl;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          vld instr    c  pc       rdy fl   e_vld e_instr  e_c e_pc     e_ir
    vt[0]  = '{1'b1, 16'hF230, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hF230, 1'b0, 16'h0000, 1'b1};
    vt[1]  = '{1'b1, 16'hF400, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 16'hF400, 1'b1, 16'h0002, 1'b1};
    vt[2]  = '{1'b1, 16'hF500, 1'b0, 16'h0004, 1'b1, 1'b0, 1'b1, 16'hF500, 1'b0, 16'h0004, 1'b1};
    vt[3]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, NOP,      1'b0, 16'h0000, 1'b1};
    vt[4]  = '{1'b1, 16'h00A1, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b1, 16'h00A1, 1'b1, 16'h0010, 1'b1};
    vt[5]  = '{1'b1, 16'h00A2, 1'b0, 16'h0012, 1'b0, 1'b0, 1'b1, 16'h00A1, 1'b1, 16'h0010, 1'b0};
    vt[6]  = '{1'b1, 16'h00A3, 1'b1, 16'h0014, 1'b0, 1'b0, 1'b1, 16'h00A1, 1'b1, 16'h0010, 1'b0};
    vt[7]  = '{1'b1, 16'h00A3, 1'b1, 16'h0014, 1'b1, 1'b0, 1'b1, 16'h00A2, 1'b0, 16'h0012, 1'b1};
    vt[8]  = '{1'b1, 16'h00A3, 1'b1, 16'h0014, 1'b0, 1'b0, 1'b1, 16'h00A2, 1'b0, 16'h0012, 1'b0};
    vt[9]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h00A3, 1'b1, 16'h0014, 1'b1};
    vt[10] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, NOP,      1'b0, 16'h0000, 1'b1};
    vt[11] = '{1'b1, 16'h00B1, 1'b1, 16'h0020, 1'b0, 1'b0, 1'b1, 16'h00B1, 1'b1, 16'h0020, 1'b1};
    vt[12] = '{1'b1, 16'h00B2, 1'b0, 16'h0022, 1'b0, 1'b0, 1'b1, 16'h00B1, 1'b1, 16'h0020, 1'b0};
    vt[13] = '{1'b1, 16'h00B3, 1'b1, 16'h0024, 1'b0, 1'b1, 1'b0, NOP,      1'b0, 16'h0000, 1'b1};
    vt[14] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, NOP,      1'b0, 16'h0000, 1'b1};
    vt[15] = '{1'b1, 16'h00C1, 1'b0, 16'h0030, 1'b1, 1'b0, 1'b1, 16'h00C1, 1'b0, 16'h0030, 1'b1};
    vt[16] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, NOP,      1'b0, 16'h0000, 1'b1};
    vt[17] = '{1'b1, 16'h00D1, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b1, 16'h00D1, 1'b1, 16'h0040, 1'b1};
    vt[18] = '{1'b1, 16'h00D2, 1'b0, 16'h0042, 1'b1, 1'b1, 1'b0, NOP,      1'b0, 16'h0000, 1'b1};

    // Reset held over two rising edges.
    step();
    step();
    check_outs(100, 1'b0, NOP, 1'b0, 16'h0000, 1'b1);
    check("stall_count_rst", 100, 32'(stall_count), 32'h0);
    check("flush_count_rst", 100, 32'(flush_count), 32'h0);
    rst = 1'b0;

    foreach (vt[i]) begin
      drive(vt[i].vld, vt[i].instr, vt[i].ctrl, vt[i].pc, vt[i].rdy, vt[i].fl);
      step();
      check_outs(i, vt[i].e_vld, vt[i].e_instr, vt[i].e_ctrl, vt[i].e_pc, vt[i].e_ir);
`ifndef IFID_PERF_CNT_EN
      check("stall_count_off", i, 32'(stall_count), 32'h0);
      check("flush_count_off", i, 32'(flush_count), 32'h0);
`endif
    end

    // Asynchronous reset asserted between edges while streaming and while FULL.
    drive(1'b1, 16'h00E1, 1'b1, 16'h0050, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h00E2, 1'b0, 16'h0052, 1'b0, 1'b0);
    step();
    check_outs(200, 1'b1, 16'h00E1, 1'b1, 16'h0050, 1'b0);
    drive(1'b1, 16'h00E3, 1'b1, 16'h0054, 1'b1, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check_outs(201, 1'b0, NOP, 1'b0, 16'h0000, 1'b1);
    check("stall_count_arst", 201, 32'(stall_count), 32'h0);
    step();
    rst = 1'b0;
    drive(1'b1, 16'h00F1, 1'b0, 16'h0060, 1'b1, 1'b0);
    step();
    check_outs(202, 1'b1, 16'h00F1, 1'b0, 16'h0060, 1'b1);
    drive(1'b1, 16'h00F2, 1'b1, 16'h0062, 1'b1, 1'b0);
    step();
    check_outs(203, 1'b1, 16'h00F2, 1'b1, 16'h0062, 1'b1);
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
    step();
    check_outs(204, 1'b0, NOP, 1'b0, 16'h0000, 1'b1);

`ifdef IFID_PERF_CNT_EN
    // Counters from a clean reset: 5 stalls + 2 flushes, then 9 more stalls to saturate CNT_W=3.
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b1, 16'h0111, 1'b0, 16'h0070, 1'b0, 1'b0);
    step();
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step();
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1);
    step();
    step();
    check("stall_count_5", 300, 32'(stall_count), 32'd5);
    check("flush_count_2", 300, 32'(flush_count), 32'd2);
    check("sat_flush_2",   300, 32'(s_flush_count), 32'd2);
    drive(1'b1, 16'h0222, 1'b0, 16'h0072, 1'b0, 1'b0);
    step();
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) step();
    check("stall_count_14", 301, 32'(stall_count), 32'd14);
    check("sat_stall_7",    301, 32'(s_stall_count), 32'd7);
    check_outs(301, 1'b1, 16'h0222, 1'b0, 16'h0072, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
